// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state and opcode
// encodings, datapath select encodings and the per-state control decode.
package mcpu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXECUTE   = 4'd7,
    ST_ALU_WB    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_ADDI_EXEC = 4'd11,
    ST_ADDI_WB   = 4'd12
  } state_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_ADDI  = 6'h08;

  localparam logic [1:0] SRCB_B        = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // fetch marks the state whose pc_write/ir_write are qualified by mem_ready
  typedef struct packed {
    logic       fetch;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  function automatic ctrl_t decode_state(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
      end
      ST_DECODE: begin
        c.alu_src_b = SRCB_IMM_SHL2;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      ST_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_ALU_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      ST_ADDI_WB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mcpu_perf_counter.sv
// Cycle and retired-instruction counters for the multi-cycle MIPS control unit.
// Only instantiated when MCPU_PERF_COUNTERS_EN is defined.
module mcpu_perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_done,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count
);

  // Free-running counters; natural 32-bit overflow provides the wrap to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (fetch_done) begin
        instr_count <= instr_count + 32'd1;
      end else begin
        instr_count <= instr_count;
      end
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle MIPS CPU.
// Optional perf counters are enabled with the MCPU_PERF_COUNTERS_EN macro.
module multicycle_control_fsm
  import mcpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        illegal_op,
`ifdef MCPU_PERF_COUNTERS_EN
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
`endif
  output logic [3:0]  state
);

  state_t state_r;
  state_t next_s;
  ctrl_t  ctrl_r;
  logic   legal_s;

  // Opcodes the datapath can execute
  always_comb begin
    case (opcode)
      OPC_RTYPE, OPC_LW, OPC_SW, OPC_BEQ, OPC_J, OPC_ADDI: legal_s = 1'b1;
      default:                                             legal_s = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    next_s = ST_FETCH;
    case (state_r)
      ST_IDLE:  next_s = ST_FETCH;
      ST_FETCH: next_s = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OPC_LW, OPC_SW: next_s = ST_MEM_ADDR;
          OPC_RTYPE:      next_s = ST_EXECUTE;
          OPC_BEQ:        next_s = ST_BRANCH;
          OPC_J:          next_s = ST_JUMP;
          OPC_ADDI:       next_s = ST_ADDI_EXEC;
          default:        next_s = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: begin
        case (opcode)
          OPC_LW:  next_s = ST_MEM_READ;
          OPC_SW:  next_s = ST_MEM_WRITE;
          default: next_s = ST_FETCH;
        endcase
      end
      ST_MEM_READ:  next_s = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WB:    next_s = ST_FETCH;
      ST_MEM_WRITE: next_s = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_EXECUTE:   next_s = ST_ALU_WB;
      ST_ALU_WB:    next_s = ST_FETCH;
      ST_BRANCH:    next_s = ST_FETCH;
      ST_JUMP:      next_s = ST_FETCH;
      ST_ADDI_EXEC: next_s = ST_ADDI_WB;
      ST_ADDI_WB:   next_s = ST_FETCH;
      default:      next_s = ST_FETCH;
    endcase
  end

  // State register; control word is decoded from next state so it lines up with state_r
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ctrl_r  <= '0;
    end else begin
      state_r <= next_s;
      ctrl_r  <= decode_state(next_s);
    end
  end

  // FETCH pc/ir loads complete with the memory; illegal_op is the DECODE-cycle opcode check
  assign pc_write      = ctrl_r.pc_write | (ctrl_r.fetch & mem_ready);
  assign ir_write      = ctrl_r.fetch & mem_ready;
  assign illegal_op    = (state_r == ST_DECODE) & ~legal_s;
  assign pc_write_cond = ctrl_r.pc_write_cond;
  assign i_or_d        = ctrl_r.i_or_d;
  assign mem_read      = ctrl_r.mem_read;
  assign mem_write     = ctrl_r.mem_write;
  assign mem_to_reg    = ctrl_r.mem_to_reg;
  assign reg_dst       = ctrl_r.reg_dst;
  assign reg_write     = ctrl_r.reg_write;
  assign alu_src_a     = ctrl_r.alu_src_a;
  assign alu_src_b     = ctrl_r.alu_src_b;
  assign alu_op        = ctrl_r.alu_op;
  assign pc_source     = ctrl_r.pc_source;
  assign state         = state_r;

`ifdef MCPU_PERF_COUNTERS_EN
  mcpu_perf_counter u_perf (
    .clk         (clk),
    .reset       (reset),
    .fetch_done  ((state_r == ST_FETCH) & mem_ready),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );
`endif

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit for the multi-cycle MIPS CPU.
- Sequences the shared datapath (PC, instruction register, unified memory, register file, ALU) through fetch, decode, execute, memory and write-back cycles.
- Next-state decisions use the opcode field from the instruction decoder. Every datapath enable and mux select is driven from here.
- Supports a memory wait handshake.

Parameters:
- OPC_RTYPE, 6'h00, R-type opcode
- OPC_LW, 6'h23, load word
- OPC_SW, 6'h2B, store word
- OPC_BEQ, 6'h04, branch-equal
- OPC_J, 6'h02, jump
- OPC_ADDI, 6'h08, add immediate

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from decoder; sampled in DECODE
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by ALU zero (datapath ANDs)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR
- reg_dst  out  1  destination select: 0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = A register
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = funct-decoded
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- States (4-bit encoding, in order): IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12.
- Reset:
  - reset=1 forces state to IDLE at the next edge, including mid-instruction; this aborts any pending access.
  - In IDLE every output is 0.
  - IDLE always goes to FETCH on the next cycle.
- Outputs are a Moore decode of state. The only exceptions are pc_write and ir_write in FETCH, which are gated by mem_ready. Any output not listed for a state is 0.
- Per-state outputs and transitions:
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=mem_ready, pc_write=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Branch on opcode:
    - LW or SW → MEM_ADDR
    - RTYPE → EXECUTE
    - BEQ → BRANCH
    - J → JUMP
    - ADDI → ADDI_EXEC
    - any other opcode → FETCH, with illegal_op=1 for this cycle only
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_READ for LW, MEM_WRITE for SW.
  - MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALU_WB.
  - ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Go to FETCH.
  - JUMP: pc_write=1, pc_source=10. Go to FETCH.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDI_WB.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- Memory handshake:
  - mem_read and mem_write stay asserted continuously while waiting.
  - mem_read and mem_write are never both high in the same cycle.
  - mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Latency with mem_ready tied high (cycles per instruction): R=4, LW=5, SW=4, BEQ=3, J=3, ADDI=4.
- opcode is only sampled in DECODE and MEM_ADDR. The IR is stable from DECODE until the next FETCH.
- Unreachable encodings (13–15) go to FETCH.

Optional Feature:
- Macro: MCPU_PERF_COUNTERS_EN.
- When defined, two extra ports are added: cycle_count out 32 and instr_count out 32.
  - cycle_count increments on every non-reset cycle.
  - instr_count increments on each FETCH→DECODE transition.
  - Both clear on reset and wrap from 32'hFFFFFFFF to 0.
- When undefined, neither the ports nor the logic exist, and all other behaviour is identical.

Decomposition:
- Shared package (mcpu_pkg): state encodings, opcode constants, alu_src_b / alu_op / pc_source encodings.
- Optional sub-module mcpu_perf_counter holds the two counters, instantiated only under the macro.
- The FSM itself stays in one module: state register, next-state logic and output decode.

Test Plan:
- Reset behaviour: reset held 3 cycles, with mem_ready=1 → all outputs 0, state=IDLE. After release: FETCH on cycle 1 with mem_read=1, pc_write=1, ir_write=1.
- R-type: add $3,$1,$2 (opcode 0x00, instr 0x00221820), mem_ready=1 → states 1,2,7,8 then 1. ALU_WB asserts reg_write=1, reg_dst=1; EXECUTE asserts alu_op=10.
- Load and store with waits: lw 0x8C220004 with mem_ready=0 for 2 cycles in MEM_READ → sequence 1,2,3,4,4,4,5. Then sw 0xAC220004 → 1,2,3,6,1 with mem_write=1 and i_or_d=1 in state 6.
- Branch and jump: beq 0x10220003 → BRANCH asserts pc_write_cond=1, pc_source=01, alu_op=01. j 0x08000010 → JUMP asserts pc_write=1, pc_source=10; 3 cycles each.
- Illegal opcode and mid-instruction reset: opcode 0x3F → illegal_op pulses exactly 1 cycle in DECODE, then FETCH. Separately, reset asserted in MEM_READ → IDLE next cycle with mem_read=0.
- With MCPU_PERF_COUNTERS_EN: 6 back-to-back ADDI (0x20220005), mem_ready=1 → instr_count=6, cycle_count=25 (1 IDLE cycle + 6×4).
